// File: rtl/cp0_timer_ctrl_pkg.sv
// Shared constants for the CP0 block: register numbers, exception codes
// and SR/Cause bit positions.
package cp0_timer_ctrl_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int SR_IE      = 0;
    localparam int SR_EXL     = 1;
    localparam int IM_LO      = 8;
    localparam int IM_HI      = 15;
    localparam int IP_LO      = 8;
    localparam int IP_HI      = 15;
    localparam int IP_SW_HI   = 9;
    localparam int CAUSE_BD   = 31;
    localparam int EXCCODE_LO = 2;
    localparam int EXCCODE_HI = 6;

    // Address-error exceptions are the only ones that latch BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// Count/Compare timer: prescaled Count, Compare match, sticky TI flag.
module cp0_count_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wd_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam logic [3:0] PRESC_MAX = 4'(COUNT_DIV - 1);

    logic [3:0]  presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        tick;

    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        presc_d   = tick ? 4'd0 : presc_q + 4'd1;
        count_d   = tick ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (tick && ((count_q + 32'd1) == compare_q))
            ti_d = 1'b1;
        // A Count write restarts the prescaler and suppresses this cycle's match.
        if (count_we_i) begin
            presc_d = 4'd0;
            count_d = wd_i;
            ti_d    = ti_q;
        end
        if (compare_we_i) begin
            compare_d = wd_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_timer_ctrl.sv
// Coprocessor 0 beside the M stage: exception/interrupt arbitration,
// SR/Cause/EPC/BadVAddr/PRId and the Count/Compare timer.
module cp0_timer_ctrl
    import cp0_timer_ctrl_pkg::*;
#(
    parameter int          HW_INT_N  = 5,
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] SR_INIT   = 32'h0000FF11,
    parameter logic [31:0] PRID      = 32'h0001BF52
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          addr,
    input  logic                we,
    input  logic [31:0]         wd,
    input  logic [31:0]         pc4_m,
    input  logic [4:0]          exc_code_m,
    input  logic                exc_bd,
    input  logic [31:0]         bad_vaddr_m,
    input  logic                eret,
    input  logic [HW_INT_N-1:0] hw_int,
    output logic                exc_handle,
    output logic [31:0]         epc,
    output logic [31:0]         data_out,
    output logic                timer_irq
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count, compare;
    logic        ti;
    logic [4:0]  hw_ext;
    logic [7:0]  ip_now;
    logic        irq_pending;
    logic [4:0]  exc_code_rec;
    logic        unused_pc_lsb;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_hw
            if (gi < HW_INT_N) begin : g_used
                assign hw_ext[gi] = hw_int[gi];
            end else begin : g_tied
                assign hw_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign unused_pc_lsb = ^pc4_m[1:0];

    cp0_count_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .count_we_i   (we && (addr == REG_COUNT)),
        .compare_we_i (we && (addr == REG_COMPARE)),
        .wd_i         (wd),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    assign ip_now       = {ti, hw_ext, cause_q[IP_SW_HI:IP_LO]};
    assign irq_pending  = sr_q[SR_IE] & (|(ip_now & sr_q[IM_HI:IM_LO]));
    assign exc_handle   = ~sr_q[SR_EXL] & (irq_pending | (exc_code_m != EXC_INT));
    assign exc_code_rec = irq_pending ? EXC_INT : exc_code_m;

    always_comb begin
        sr_d                   = sr_q;
        cause_d                = cause_q;
        epc_d                  = epc_q;
        badvaddr_d             = badvaddr_q;
        cause_d[IP_HI:IP_LO]   = ip_now;
        if (exc_handle) begin
            epc_d                          = {pc4_m[31:2], 2'b00} - (exc_bd ? 32'd8 : 32'd4);
            sr_d[SR_EXL]                   = 1'b1;
            cause_d[EXCCODE_HI:EXCCODE_LO] = exc_code_rec;
            cause_d[CAUSE_BD]              = exc_bd;
            if (is_addr_exc(exc_code_rec))
                badvaddr_d = bad_vaddr_m;
        end else if (eret) begin
            sr_d[SR_EXL] = 1'b0;
        end else if (we) begin
            case (addr)
                REG_SR:    sr_d = wd;
                REG_CAUSE: cause_d[IP_SW_HI:IP_LO] = wd[IP_SW_HI:IP_LO];
                REG_EPC:   epc_d = wd;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= SR_INIT;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            sr_q       <= sr_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        case (addr)
            REG_BADVADDR: data_out = badvaddr_q;
            REG_COUNT:    data_out = count;
            REG_COMPARE:  data_out = compare;
            REG_SR:       data_out = sr_q;
            REG_CAUSE:    data_out = cause_q;
            REG_EPC:      data_out = epc_q;
            REG_PRID:     data_out = PRID;
            default:      data_out = 32'd0;
        endcase
    end

    assign epc       = epc_q;
    assign timer_irq = ti;

endmodule
